// File: rtl/fifolifo_rr_arbiter.sv
// Round-robin write arbiter and pop sequencer in front of a shared FIFO/LIFO buffer.
// Optional drop statistics counter enabled by defining FIFOLIFO_ARB_STATS_EN.
module fifolifo_rr_arbiter #(
    parameter logic MODE      = 1'b1,
    parameter int   dat_width = 32,
    parameter int   DEPTH     = 64,
    parameter int   L         = 6
) (
    input  logic                 Wrclk,
    input  logic                 Rst,
    input  logic                 Req0,
    input  logic [dat_width-1:0] Datain0,
    output logic                 Gnt0,
    input  logic                 Req1,
    input  logic [dat_width-1:0] Datain1,
    output logic                 Gnt1,
    input  logic                 Rdreq,
    output logic                 Rdack,
    output logic                 Wren,
    output logic                 Rden,
    output logic [dat_width-1:0] Datain,
    output logic [L:0]           Count,
    output logic                 Full,
    output logic                 Empty
`ifdef FIFOLIFO_ARB_STATS_EN
    ,
    output logic [15:0]          Drop_cnt
`endif
);

    localparam logic [L:0] C_DEPTH = (L+1)'(DEPTH);
    localparam logic [L:0] C_ONE   = (L+1)'(1);
    localparam logic [L:0] C_ZERO  = (L+1)'(0);

    logic                 r_gnt0;
    logic                 r_gnt1;
    logic                 r_wren;
    logic                 r_rden;
    logic                 r_rr;
    logic [dat_width-1:0] r_datain;
    logic [L:0]           r_count;

    logic w_elig0;
    logic w_elig1;
    logic w_any_elig;
    logic w_full;
    logic w_empty;
    logic w_pop_go;
    logic w_push_go;
    logic w_winner;

    // A requester is never sampled during its own grant cycle, so a held Req is not written twice.
    assign w_elig0    = Req0 & ~r_gnt0;
    assign w_elig1    = Req1 & ~r_gnt1;
    assign w_any_elig = w_elig0 | w_elig1;
    assign w_full     = (r_count == C_DEPTH);
    assign w_empty    = (r_count == C_ZERO);
    assign w_pop_go   = Rdreq & ~w_empty;
    assign w_push_go  = w_any_elig & ~w_full & ~((MODE == 1'b0) & w_pop_go);

    // Winner select: round-robin pointer breaks ties, otherwise the lone eligible requester wins.
    always_comb begin
        w_winner = 1'b0;
        if (w_elig0 && w_elig1) begin
            w_winner = r_rr;
        end else if (w_elig1) begin
            w_winner = 1'b1;
        end else begin
            w_winner = 1'b0;
        end
    end

    // Registered strobes, grants, write data and round-robin pointer.
    always_ff @(posedge Wrclk or posedge Rst) begin
        if (Rst) begin
            r_gnt0   <= 1'b0;
            r_gnt1   <= 1'b0;
            r_wren   <= 1'b0;
            r_rden   <= 1'b0;
            r_rr     <= 1'b0;
            r_datain <= {dat_width{1'b0}};
        end else begin
            r_gnt0 <= w_push_go & ~w_winner;
            r_gnt1 <= w_push_go & w_winner;
            r_wren <= w_push_go;
            r_rden <= w_pop_go;
            if (w_push_go) begin
                r_datain <= w_winner ? Datain1 : Datain0;
                r_rr     <= ~w_winner;
            end else begin
                r_datain <= r_datain;
                r_rr     <= r_rr;
            end
        end
    end

    // Occupancy: committed at the decision edge, so Full/Empty always reflect pre-edge state.
    always_ff @(posedge Wrclk or posedge Rst) begin
        if (Rst) begin
            r_count <= C_ZERO;
        end else begin
            case ({w_push_go, w_pop_go})
                2'b10:   r_count <= r_count + C_ONE;
                2'b01:   r_count <= r_count - C_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef FIFOLIFO_ARB_STATS_EN
    logic [15:0] r_drop_cnt;

    // Saturating count of edges where an eligible request was refused because the buffer was full.
    always_ff @(posedge Wrclk or posedge Rst) begin
        if (Rst) begin
            r_drop_cnt <= 16'h0000;
        end else if (w_any_elig && w_full && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'h0001;
        end else begin
            r_drop_cnt <= r_drop_cnt;
        end
    end

    assign Drop_cnt = r_drop_cnt;
`endif

    assign Gnt0   = r_gnt0;
    assign Gnt1   = r_gnt1;
    assign Wren   = r_wren;
    assign Rden   = r_rden;
    assign Rdack  = r_rden;
    assign Datain = r_datain;
    assign Count  = r_count;
    assign Full   = w_full;
    assign Empty  = w_empty;

endmodule

// File: tb/tb_fifolifo_rr_arbiter.sv
// Scoreboard bench: a FIFO-mode and a LIFO-mode instance share stimulus, each checked per cycle.
module tb_fifolifo_rr_arbiter;

    localparam logic [31:0] A_BASE = 32'hA000_0000;
    localparam logic [31:0] B_BASE = 32'hB000_0000;

    typedef struct packed {
        logic        gnt0;
        logic        gnt1;
        logic        wren;
        logic        rden;
        logic        rr;
        logic [31:0] dat;
        logic [6:0]  count;
        logic [15:0] drop;
    } st_t;

    logic        Wrclk;
    logic        Rst;
    logic        Req0;
    logic        Req1;
    logic        Rdreq;
    logic [31:0] Datain0;
    logic [31:0] Datain1;

    logic        f_gnt0, f_gnt1, f_rdack, f_wren, f_rden, f_full, f_empty;
    logic [31:0] f_datain;
    logic [6:0]  f_count;
    logic [15:0] f_drop;
    logic        l_gnt0, l_gnt1, l_rdack, l_wren, l_rden, l_full, l_empty;
    logic [31:0] l_datain;
    logic [6:0]  l_count;
    logic [15:0] l_drop;

    int   n_checks;
    int   n_errors;
    int   idx0;
    int   idx1;
    st_t  m_f;
    st_t  m_l;
    st_t  q_f[$];
    st_t  q_l[$];

    fifolifo_rr_arbiter #(.MODE(1'b1), .dat_width(32), .DEPTH(64), .L(6)) u_dut_fifo (
        .Wrclk(Wrclk), .Rst(Rst),
        .Req0(Req0), .Datain0(Datain0), .Gnt0(f_gnt0),
        .Req1(Req1), .Datain1(Datain1), .Gnt1(f_gnt1),
        .Rdreq(Rdreq), .Rdack(f_rdack), .Wren(f_wren), .Rden(f_rden),
        .Datain(f_datain), .Count(f_count), .Full(f_full), .Empty(f_empty)
`ifdef FIFOLIFO_ARB_STATS_EN
        , .Drop_cnt(f_drop)
`endif
    );

    fifolifo_rr_arbiter #(.MODE(1'b0), .dat_width(32), .DEPTH(64), .L(6)) u_dut_lifo (
        .Wrclk(Wrclk), .Rst(Rst),
        .Req0(Req0), .Datain0(Datain0), .Gnt0(l_gnt0),
        .Req1(Req1), .Datain1(Datain1), .Gnt1(l_gnt1),
        .Rdreq(Rdreq), .Rdack(l_rdack), .Wren(l_wren), .Rden(l_rden),
        .Datain(l_datain), .Count(l_count), .Full(l_full), .Empty(l_empty)
`ifdef FIFOLIFO_ARB_STATS_EN
        , .Drop_cnt(l_drop)
`endif
    );

`ifndef FIFOLIFO_ARB_STATS_EN
    assign f_drop = 16'h0000;
    assign l_drop = 16'h0000;
`endif

    initial Wrclk = 1'b0;
    always #5 Wrclk = ~Wrclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic st_t model_step(input st_t s, input bit mode, input bit r0, input bit r1,
                                       input bit rd, input logic [31:0] d0, input logic [31:0] d1);
        st_t n;
        bit  e0, e1, full, empty, pop, push, win;
        e0    = r0 && !s.gnt0;
        e1    = r1 && !s.gnt1;
        full  = (s.count == 7'd64);
        empty = (s.count == 7'd0);
        pop   = rd && !empty;
        push  = (e0 || e1) && !full && !(!mode && pop);
        win   = (e0 && e1) ? s.rr : e1;
        n      = s;
        n.gnt0 = push && !win;
        n.gnt1 = push && win;
        n.wren = push;
        n.rden = pop;
        if (push) begin
            n.dat = win ? d1 : d0;
            n.rr  = !win;
        end
        n.count = s.count + {6'd0, push} - {6'd0, pop};
        if ((e0 || e1) && full && (s.drop != 16'hFFFF)) n.drop = s.drop + 16'd1;
        return n;
    endfunction

    task automatic compare_outputs(input string who, input st_t e,
                                   input logic gnt0, input logic gnt1, input logic wren,
                                   input logic rden, input logic rdack, input logic [31:0] dat,
                                   input logic [6:0] count, input logic full, input logic empty,
                                   input logic [15:0] drop);
        check({who, "_gnt0"},  64'(gnt0),  64'(e.gnt0));
        check({who, "_gnt1"},  64'(gnt1),  64'(e.gnt1));
        check({who, "_wren"},  64'(wren),  64'(e.wren));
        check({who, "_rden"},  64'(rden),  64'(e.rden));
        check({who, "_rdack"}, 64'(rdack), 64'(e.rden));
        check({who, "_dat"},   64'(dat),   64'(e.dat));
        check({who, "_count"}, 64'(count), 64'(e.count));
        check({who, "_full"},  64'(full),  64'(e.count == 7'd64));
        check({who, "_empty"}, 64'(empty), 64'(e.count == 7'd0));
`ifdef FIFOLIFO_ARB_STATS_EN
        check({who, "_drop"},  64'(drop),  64'(e.drop));
`else
        if (drop != 16'h0000) check({who, "_drop"}, 64'(drop), 64'd0);
`endif
    endtask

    task automatic cycle(input bit r0, input bit r1, input bit rd);
        st_t ef, el;
        Req0  = r0;
        Req1  = r1;
        Rdreq = rd;
        q_f.push_back(model_step(m_f, 1'b1, r0, r1, rd, Datain0, Datain1));
        q_l.push_back(model_step(m_l, 1'b0, r0, r1, rd, Datain0, Datain1));
        @(posedge Wrclk);
        #1;
        ef = q_f.pop_front();
        el = q_l.pop_front();
        compare_outputs("fifo", ef, f_gnt0, f_gnt1, f_wren, f_rden, f_rdack, f_datain,
                        f_count, f_full, f_empty, f_drop);
        compare_outputs("lifo", el, l_gnt0, l_gnt1, l_wren, l_rden, l_rdack, l_datain,
                        l_count, l_full, l_empty, l_drop);
        m_f = ef;
        m_l = el;
        // Requesters present their next word while their grant is high.
        if (ef.gnt0) begin idx0++; Datain0 = A_BASE + 32'(idx0); end
        if (ef.gnt1) begin idx1++; Datain1 = B_BASE + 32'(idx1); end
    endtask

    task automatic do_reset();
        Req0  = 1'b0;
        Req1  = 1'b0;
        Rdreq = 1'b0;
        Rst   = 1'b1;
        @(posedge Wrclk);
        #1;
        Rst = 1'b0;
        m_f = '0;
        m_l = '0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        idx0     = 0;
        idx1     = 0;
        Rst      = 1'b1;
        Req0     = 1'b0;
        Req1     = 1'b0;
        Rdreq    = 1'b0;
        Datain0  = A_BASE;
        Datain1  = B_BASE;
        m_f      = '0;
        m_l      = '0;
        repeat (2) @(posedge Wrclk);
        #1;
        check("rst_wren",  64'(f_wren),   64'd0);
        check("rst_gnt",   64'({f_gnt0, f_gnt1}), 64'd0);
        check("rst_rden",  64'(f_rden),   64'd0);
        check("rst_dat",   64'(f_datain), 64'd0);
        check("rst_count", 64'(f_count),  64'd0);
        check("rst_empty", 64'(f_empty),  64'd1);
        Rst = 1'b0;

        // Both requesters held: A0,B0,A1,B1 ... one push per cycle.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b1, 1'b0);
            check("alt_dat", 64'(f_datain),
                  64'((i % 2 == 0) ? (A_BASE + 32'(i / 2)) : (B_BASE + 32'(i / 2))));
            check("alt_count", 64'(f_count), 64'(i + 1));
        end

        // Reset asserted mid-cycle while Wren is high.
        cycle(1'b1, 1'b0, 1'b0);
        check("pre_rst_wren", 64'(f_wren), 64'd1);
        #3;
        Rst = 1'b1;
        #1;
        check("mid_rst_wren",  64'({f_wren, l_wren}), 64'd0);
        check("mid_rst_gnt",   64'({f_gnt0, f_gnt1, l_gnt0, l_gnt1}), 64'd0);
        check("mid_rst_rden",  64'({f_rden, l_rden}), 64'd0);
        check("mid_rst_count", 64'(f_count), 64'd0);
        check("mid_rst_empty", 64'(f_empty), 64'd1);
        #1;
        Rst = 1'b0;
        m_f = '0;
        m_l = '0;
        cycle(1'b1, 1'b1, 1'b0);
        check("post_rst_first_gnt", 64'({f_gnt0, f_gnt1}), 64'b10);

        // Single requester: at most one push every two cycles.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            check("single_wren",  64'(f_wren),  64'((i % 2 == 0) ? 1 : 0));
            check("single_count", 64'(f_count), 64'(i / 2 + 1));
        end

        // Fill to DEPTH, then refused requests, then one pop reopens a slot.
        do_reset();
        for (int i = 0; i < 64; i++) cycle(1'b1, 1'b1, 1'b0);
        check("fill_full", 64'(f_full), 64'd1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, 1'b0);
            check("full_no_wren", 64'(f_wren), 64'd0);
        end
`ifdef FIFOLIFO_ARB_STATS_EN
        check("full_drop_cnt", 64'(f_drop), 64'd3);
`endif
        cycle(1'b1, 1'b1, 1'b1);
        check("full_pop_rden",  64'(f_rden),  64'd1);
        check("full_pop_wren",  64'(f_wren),  64'd0);
        check("full_pop_count", 64'(f_count), 64'd63);
        cycle(1'b1, 1'b1, 1'b0);
        check("refill_wren",  64'(f_wren),  64'd1);
        check("refill_count", 64'(f_count), 64'd64);

        // Count=10, Req0 and Rdreq together: FIFO does both, LIFO pops first.
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b1);
        check("mode1_both",  64'({f_wren, f_rden}), 64'b11);
        check("mode1_count", 64'(f_count), 64'd10);
        check("mode0_pop",   64'({l_wren, l_rden}), 64'b01);
        check("mode0_count", 64'(l_count), 64'd9);
        cycle(1'b1, 1'b0, 1'b0);
        check("mode0_late_push", 64'(l_wren),  64'd1);
        check("mode0_count2",    64'(l_count), 64'd10);

        // Empty: no bypass, pop follows on the next edge.
        do_reset();
        cycle(1'b0, 1'b1, 1'b1);
        check("empty_wren_only", 64'({f_wren, f_rden}), 64'b10);
        check("empty_count",     64'(f_count), 64'd1);
        cycle(1'b0, 1'b0, 1'b1);
        check("empty_next_rden", 64'(f_rden),  64'd1);
        check("empty_count2",    64'(f_count), 64'd0);

        // Random traffic against the scoreboard.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) < 4) ? 1'b1 : 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
